// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB timer: register offsets, CTRL field positions
// and the APB handshake state encoding.
package apb_timer_pkg;

    localparam logic [4:0] TMR_CTRL   = 5'h00;
    localparam logic [4:0] TMR_LOAD   = 5'h04;
    localparam logic [4:0] TMR_COUNT  = 5'h08;
    localparam logic [4:0] TMR_STATUS = 5'h0C;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_AUTO_BIT   = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 2;
    localparam int unsigned CTRL_PRE_LSB    = 8;
    localparam int unsigned CTRL_PRE_MSB    = 15;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_state_e;

endpackage

// File: rtl/apb_timer_if.sv
// APB3 bus bundle between the AXI-to-APB master and the timer completer.
interface apb_timer_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_timer_core.sv
// Prescaler, 32-bit down counter, auto-reload and expiry flag of the timer.
module apb_timer_core (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_auto_reload,
    input  logic [7:0]  i_prescale,
    input  logic [31:0] i_load,
    input  logic        i_count_wr,
    input  logic [31:0] i_count_wdata,
    input  logic        i_pcnt_clr,
    input  logic        i_expired_clr,
    output logic [31:0] o_count,
    output logic        o_expired,
    output logic        o_en_clear
);

    logic [7:0]  r_pcnt;
    logic [31:0] r_count;
    logic        r_expired;
    logic [7:0]  w_pcnt_d;
    logic [31:0] w_count_d;
    logic        w_expired_d;
    logic        w_tick;
    logic        w_expire;

    always_comb begin
        w_tick      = i_en & (r_pcnt == i_prescale);
        w_expire    = w_tick & (r_count == '0);
        w_pcnt_d    = r_pcnt;
        w_count_d   = r_count;
        w_expired_d = r_expired;

        if (i_count_wr || i_pcnt_clr || w_tick) begin
            w_pcnt_d = '0;
        end else if (i_en) begin
            w_pcnt_d = r_pcnt + 8'd1;
        end

        // A bus write to COUNT overrides whatever the tick would have done.
        if (i_count_wr) begin
            w_count_d = i_count_wdata;
        end else if (w_tick) begin
            if (r_count != '0) begin
                w_count_d = r_count - 32'd1;
            end else if (i_auto_reload) begin
                w_count_d = i_load;
            end
        end

        if (w_expire) begin
            w_expired_d = 1'b1;
        end else if (i_expired_clr) begin
            w_expired_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pcnt    <= '0;
            r_count   <= '0;
            r_expired <= 1'b0;
        end else begin
            r_pcnt    <= w_pcnt_d;
            r_count   <= w_count_d;
            r_expired <= w_expired_d;
        end
    end

    assign o_count    = r_count;
    assign o_expired  = r_expired;
    assign o_en_clear = w_expire & ~i_auto_reload;

endmodule

// File: rtl/apb_timer.sv
// APB3 completer for the programmable down-counting timer: handshake FSM with
// configurable wait states, address decode and the CTRL/LOAD register file.
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    apb_timer_if.slave  s_apb,
    output logic        o_irq
);

    apb_state_e  r_state;
    apb_state_e  w_state_d;
    logic [3:0]  r_wcnt;
    logic [3:0]  w_wcnt_d;

    logic        r_en;
    logic        r_auto;
    logic        r_irq_en;
    logic [7:0]  r_prescale;
    logic [31:0] r_load;
    logic        r_irq;

    logic [4:0]  w_off;
    logic        w_err;
    logic        w_pready;
    logic        w_wr;
    logic        w_ctrl_wr;
    logic        w_load_wr;
    logic        w_count_wr;
    logic        w_status_clr;
    logic        w_pcnt_clr;
    logic [31:0] w_rdata;
    logic [31:0] w_count;
    logic        w_expired;
    logic        w_en_clear;
    logic        w_unused;

    assign w_unused = ^s_apb.paddr[ADDR_WIDTH-1:5];

    assign w_off    = s_apb.paddr[4:0];
    assign w_err    = (w_off[1:0] != 2'b00) || (w_off > TMR_STATUS);
    assign w_pready = s_apb.psel & s_apb.penable & (r_state == ACCESS) & (r_wcnt == 4'd0);

    always_comb begin
        w_state_d = r_state;
        w_wcnt_d  = r_wcnt;
        unique case (r_state)
            IDLE: begin
                if (s_apb.psel && !s_apb.penable) begin
                    w_state_d = ACCESS;
                    w_wcnt_d  = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                // A dropped PSEL abandons the transfer rather than hanging.
                if (w_pready || !s_apb.psel) begin
                    w_state_d = IDLE;
                end else if (r_wcnt != 4'd0) begin
                    w_wcnt_d = r_wcnt - 4'd1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_d;
            r_wcnt  <= w_wcnt_d;
        end
    end

    assign w_wr         = w_pready & s_apb.pwrite & ~w_err;
    assign w_ctrl_wr    = w_wr & (w_off == TMR_CTRL);
    assign w_load_wr    = w_wr & (w_off == TMR_LOAD);
    assign w_count_wr   = w_wr & (w_off == TMR_COUNT);
    assign w_status_clr = w_wr & (w_off == TMR_STATUS) & s_apb.pwdata[0];
    assign w_pcnt_clr   = w_ctrl_wr & s_apb.pwdata[CTRL_EN_BIT] & ~r_en;

    // A CTRL write takes precedence over the one-shot self-disable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_prescale <= '0;
            r_load     <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_en       <= s_apb.pwdata[CTRL_EN_BIT];
                r_auto     <= s_apb.pwdata[CTRL_AUTO_BIT];
                r_irq_en   <= s_apb.pwdata[CTRL_IRQ_EN_BIT];
                r_prescale <= s_apb.pwdata[CTRL_PRE_MSB:CTRL_PRE_LSB];
            end else if (w_en_clear) begin
                r_en <= 1'b0;
            end
            if (w_load_wr) begin
                r_load <= s_apb.pwdata;
            end
            r_irq <= w_expired & r_irq_en;
        end
    end

    apb_timer_core u_core (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (r_en),
        .i_auto_reload (r_auto),
        .i_prescale    (r_prescale),
        .i_load        (r_load),
        .i_count_wr    (w_count_wr),
        .i_count_wdata (s_apb.pwdata),
        .i_pcnt_clr    (w_pcnt_clr),
        .i_expired_clr (w_status_clr),
        .o_count       (w_count),
        .o_expired     (w_expired),
        .o_en_clear    (w_en_clear)
    );

    always_comb begin
        w_rdata = '0;
        case (w_off)
            TMR_CTRL:   w_rdata = {16'h0, r_prescale, 5'h0, r_irq_en, r_auto, r_en};
            TMR_LOAD:   w_rdata = r_load;
            TMR_COUNT:  w_rdata = w_count;
            TMR_STATUS: w_rdata = {31'h0, w_expired};
            default:    w_rdata = '0;
        endcase
    end

    assign s_apb.pready  = w_pready;
    assign s_apb.pslverr = w_pready & w_err;
    assign s_apb.prdata  = (w_pready && !s_apb.pwrite && !w_err) ? w_rdata : '0;
    assign o_irq         = r_irq;

endmodule

// File: tb/tb_apb_timer.sv
// Scoreboard bench for apb_timer: the driver queues expected responses, a
// negedge monitor checks each completed transfer plus wait-state count.
module tb_apb_timer;
    import apb_timer_pkg::*;

    localparam int unsigned WS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;

    apb_timer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_timer #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .WAIT_STATES (WS)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .s_apb   (bus),
        .o_irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   commit_cyc = 0;
    int   wait_seen = 0;
    int   exp_rise[$];
    int   irq_rise[$];
    logic prev_exp = 1'b0;
    logic prev_irq = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per completed transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            wait_seen = 0;
        end else if (bus.psel && bus.penable) begin
            if (!bus.pready) begin
                wait_seen++;
            end else begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: got a completion, expected none");
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_err"}, {31'h0, bus.pslverr}, {31'h0, e.err});
                    if (e.chk) check({e.name, "_rdata"}, bus.prdata, e.rdata);
                    check({e.name, "_waits"}, wait_seen, WS);
                end
                wait_seen = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (dut.u_core.o_expired && !prev_exp) exp_rise.push_back(cyc);
        if (irq && !prev_irq) irq_rise.push_back(cyc);
        prev_exp = dut.u_core.o_expired;
        prev_irq = irq;
    end

    // Called at posedge+1; returns at posedge+1 after the commit edge with the
    // bus still selected, so consecutive calls are back-to-back.
    task automatic xfer(input string name, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic chk);
        bit done = 1'b0;
        sb_q.push_back('{name, exp_rdata, exp_err, chk});
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.paddr   = addr;
        bus.pwrite  = wr;
        bus.pwdata  = wdata;
        @(posedge clk);
        #1 bus.penable = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (bus.pready) done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no PREADY in 50 cycles, expected PREADY", name);
        end
        @(posedge clk);
        #1 commit_cyc = cyc;
    endtask

    task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] d);
        xfer(name, addr, 1'b1, d, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        xfer(name, addr, 1'b0, 32'h0, exp, 1'b0, 1'b1);
    endtask

    task automatic idle();
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input bit use_irq, input int n, input string name);
        bit done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            #1;
            if ((use_irq ? irq_rise.size() : exp_rise.size()) >= n) done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got fewer than %0d rises, expected %0d", name, n, n);
        end
        @(posedge clk);
        #1;
    endtask

    int t_en;
    int t_a;

    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pready", {31'h0, bus.pready}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        rd("rst_ctrl", 32'h00, 32'h0);
        rd("rst_load", 32'h04, 32'h0);
        rd("rst_count", 32'h08, 32'h0);
        rd("rst_status", 32'h0C, 32'h0);
        wr("load_wr", 32'h04, 32'h1234);
        rd("load_rd", 32'h04, 32'h0000_1234);
        idle();

        // Auto-reload: period (3+1)*(3+1) = 16 cycles
        wr("ar_load", 32'h04, 32'd3);
        wr("ar_count", 32'h08, 32'd3);
        exp_rise.delete(); irq_rise.delete();
        wr("ar_ctrl", 32'h00, 32'h0000_0307);
        t_en = commit_cyc;
        idle();
        wait_rise(1'b0, 1, "ar_exp1");
        if (exp_rise.size() >= 1) check("ar_exp1_lat", exp_rise[0] - t_en, 16);
        wait_rise(1'b1, 1, "ar_irq1");
        if (irq_rise.size() >= 1) check("ar_irq1_lat", irq_rise[0] - t_en, 17);
        wr("ar_clr", 32'h0C, 32'h1);
        idle();
        wait_rise(1'b0, 2, "ar_exp2");
        if (exp_rise.size() >= 2) check("ar_period", exp_rise[1] - exp_rise[0], 16);
        wait_rise(1'b1, 2, "ar_irq2");
        if (irq_rise.size() >= 2 && exp_rise.size() >= 2)
            check("ar_irq2_lat", irq_rise[1] - exp_rise[1], 1);
        wr("ar_stop", 32'h00, 32'h0);
        wr("ar_clr2", 32'h0C, 32'h1);
        idle();

        // One-shot, COUNT=2, PRESCALE=0: expiry 3 cycles after EN
        wr("os_count", 32'h08, 32'd2);
        exp_rise.delete();
        wr("os_ctrl", 32'h00, 32'h0000_0001);
        t_en = commit_cyc;
        idle();
        wait_rise(1'b0, 1, "os_exp");
        if (exp_rise.size() >= 1) check("os_exp_lat", exp_rise[0] - t_en, 3);
        rd("os_ctrl_rd", 32'h00, 32'h0);
        rd("os_count_rd", 32'h08, 32'h0);
        rd("os_status_rd", 32'h0C, 32'h1);
        wr("os_clr", 32'h0C, 32'h1);
        rd("os_status_clr", 32'h0C, 32'h0);

        // STATUS clear lands on the same edge as the expiry set
        wr("co_count", 32'h08, 32'd3);
        wr("co_ctrl", 32'h00, 32'h0000_0005);
        t_a = commit_cyc;
        wr("co_clr", 32'h0C, 32'h1);
        check("co_xfer_len", commit_cyc - t_a, 4);
        rd("co_status", 32'h0C, 32'h1);
        rd("co_ctrl_rd", 32'h00, 32'h0000_0004);
        idle();
        check("co_irq", {31'h0, irq}, 32'h1);

        // Reset in the middle of a write
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h04; bus.pwdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 bus.penable = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pready", {31'h0, bus.pready}, 32'h0);
        check("mid_rst_pslverr", {31'h0, bus.pslverr}, 32'h0);
        check("mid_rst_prdata", bus.prdata, 32'h0);
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd("post_rst_ctrl", 32'h00, 32'h0);
        rd("post_rst_load", 32'h04, 32'h0);
        rd("post_rst_status", 32'h0C, 32'h0);

        // COUNT write on the same edge as a tick (PRESCALE=3)
        wr("cw_count0", 32'h08, 32'h100);
        wr("cw_ctrl", 32'h00, 32'h0000_0301);
        t_a = commit_cyc;
        wr("cw_count", 32'h08, 32'h10);
        check("cw_align", commit_cyc - t_a, 4);
        check("cw_pcnt", {24'h0, dut.u_core.r_pcnt}, 32'h0);
        rd("cw_count_rd", 32'h08, 32'h10);
        wr("cw_stop", 32'h00, 32'h0);

        // Error responses
        wr("er_count", 32'h08, 32'h77);
        xfer("er_rd14", 32'h14, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        xfer("er_wr0a", 32'h0A, 1'b1, 32'h55, 32'h0, 1'b1, 1'b0);
        rd("er_count_rd", 32'h08, 32'h77);
        xfer("er_rd10", 32'h10, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        xfer("er_rd01", 32'h01, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        idle();
        repeat (2) @(posedge clk);

        check("sb_empty", sb_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
